// File: rtl/main_memory_ctrl.sv
// Line-granular main-memory model behind the data cache's memory-side port.
// One line read or write per request, fixed LATENCY from accept to a
// single-cycle ack. Array contents survive reset; a pending write is dropped.
module main_memory_ctrl #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [LINE_W-1:0]   mem_q [DEPTH];

  // Byte-offset bits and index bits above the array size are don't-care (aliasing).
  logic [IDX_W-1:0]    addr_idx;
  logic                unused_addr;
  assign addr_idx    = addr_i[5 +: IDX_W];
  assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  // State and request registers; reset drops any in-flight request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Line array is not reset; a write commits on the edge leaving ACK, which
  // is always before the next request can be accepted in IDLE.
  always_ff @(posedge clk_i) begin
    if (state_q == ACK && wr_q) mem_q[idx_q] <= wdata_q;
  end

  // Next-state logic: IDLE accepts, WAIT counts down, ACK lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable_i) state_d = (LATENCY == 1) ? ACK : WAIT;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, latency counter, and read data capture on ACK entry.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && enable_i) begin
      cnt_d   = CNT_W'(LATENCY - 1);
      idx_d   = addr_idx;
      wr_d    = write_i;
      wdata_d = data_i;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // idx_d/wr_d already select the fresh request when LATENCY=1 jumps IDLE->ACK.
    if (state_d == ACK && state_q != ACK && !wr_d) rdata_d = mem_q[idx_d];
  end

  // Outputs depend on registered state only.
  always_comb begin
    ack_o  = (state_q == ACK);
    busy_o = (state_q != IDLE);
    data_o = rdata_q;
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench: a slow (LATENCY=10) and a fast (LATENCY=1) instance
// share the same stimulus; a timestamp-based transaction model predicts ack,
// busy and data_o for each instance every cycle.
module tb_main_memory_ctrl;
  localparam int LW = 256;
  localparam int DEPTH = 512;
  localparam int LAT0 = 10;
  localparam int LAT1 = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   addr = '0;
  logic [LW-1:0] din = '0;
  logic          en = 1'b0;
  logic          wr = 1'b0;
  logic          ack0, ack1, busy0, busy1;
  logic [LW-1:0] dout0, dout1;

  int n_chk = 0;
  int n_err = 0;
  bit mon_on = 0;

  always #5 clk = ~clk;

  main_memory_ctrl #(.LINE_W(LW), .DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(din), .enable_i(en),
    .write_i(wr), .ack_o(ack0), .data_o(dout0), .busy_o(busy0));

  main_memory_ctrl #(.LINE_W(LW), .DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(din), .enable_i(en),
    .write_i(wr), .ack_o(ack1), .data_o(dout1), .busy_o(busy1));

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd256();
    logic [LW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- reference model (transaction timestamps) ----------------
  int            lat_m   [2] = '{LAT0, LAT1};
  logic [LW-1:0] mmem    [2][DEPTH];
  bit            m_busy  [2] = '{0, 0};
  bit            m_ack   [2] = '{0, 0};
  logic [LW-1:0] m_dout  [2] = '{'0, '0};
  longint        t_done  [2];
  int            p_idx   [2];
  bit            p_wr    [2];
  logic [LW-1:0] p_data  [2];
  longint        edge_no = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_ack[k] = 0; m_dout[k] = '0;
      end
    end else begin
      edge_no++;
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k]) begin
          if (edge_no == t_done[k]) begin
            if (p_wr[k]) mmem[k][p_idx[k]] = p_data[k];
            m_busy[k] = 0;
          end
        end else if (en) begin
          m_busy[k] = 1;
          t_done[k] = edge_no + lat_m[k];
          p_idx[k]  = int'(addr / 32) % DEPTH;
          p_wr[k]   = wr;
          p_data[k] = din;
        end
        m_ack[k] = m_busy[k] && (edge_no == t_done[k] - 1);
        if (m_ack[k] && !p_wr[k]) m_dout[k] = mmem[k][p_idx[k]];
      end
    end
  end

  // Cycle-by-cycle compare of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      chk("ack0",  LW'(ack0),  LW'(m_ack[0]));
      chk("busy0", LW'(busy0), LW'(m_busy[0]));
      chk("dout0", dout0,      m_dout[0]);
      chk("ack1",  LW'(ack1),  LW'(m_ack[1]));
      chk("busy1", LW'(busy1), LW'(m_busy[1]));
      chk("dout1", dout1,      m_dout[1]);
    end
  end

  // ---------------- stimulus ----------------
  int            lat0, lat1, nack0, nbusy0;
  logic [LW-1:0] rd0, rd1;

  // One request pulse, then 20 observed cycles (optionally churning inputs).
  task automatic run_req(input logic [31:0] a, input logic w, input logic [LW-1:0] d, input bit churn);
    lat0 = 0; lat1 = 0; nack0 = 0; nbusy0 = 0; rd0 = 'x; rd1 = 'x;
    @(negedge clk);
    addr = a; wr = w; din = d; en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      en = 1'b0;
      if (ack0) begin nack0++; if (lat0 == 0) begin lat0 = i; rd0 = dout0; end end
      if (ack1 && lat1 == 0) begin lat1 = i; rd1 = dout1; end
      if (busy0) nbusy0++;
      if (churn) begin addr = $urandom(); din = rnd256(); wr = 1'($urandom()); end
    end
  endtask

  function automatic logic [31:0] line_addr(input int line);
    return ($urandom() & 32'hFFFF_C000) | (32'(line) << 5) | ($urandom() & 32'h1F);
  endfunction

  logic [LW-1:0] a5, d_old, d_new, dz, d5, pre;
  int            acks[$];

  initial begin
    a5 = {32{8'hA5}};
    repeat (3) @(negedge clk);
    chk("rst_ack0", LW'(ack0), '0);
    chk("rst_busy0", LW'(busy0), '0);
    chk("rst_dout0", dout0, '0);
    chk("rst_dout1", dout1, '0);
    rst_n = 1'b1;
    mon_on = 1;

    // Fill lines 0..15 so later reads are defined.
    for (int l = 0; l < 16; l++) run_req(32'(l) << 5, 1'b1, rnd256(), 0);

    // Read latency on line 3.
    run_req(32'h60, 1'b1, a5, 0);
    run_req(32'h60, 1'b0, rnd256(), 0);
    chk("t1_lat", LW'(lat0), LW'(LAT0));
    chk("t1_data", rd0, a5);
    chk("t1_nack", LW'(nack0), 1);
    chk("t1_busy", LW'(nbusy0), LW'(LAT0));
    chk("t1_lat_fast", LW'(lat1), 1);

    // Write then read line 7; the write ack leaves data_o alone.
    pre = dout0;
    run_req(32'hE0, 1'b1, LW'(256'h1234), 0);
    chk("t2_wr_hold", dout0, pre);
    run_req(32'hE0, 1'b0, '0, 0);
    chk("t2_rd", rd0, LW'(256'h1234));

    // Back-to-back reads with enable held high.
    @(negedge clk);
    addr = 32'h60; wr = 1'b0; en = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (ack0) acks.push_back(i);
    end
    en = 1'b0;
    repeat (15) @(negedge clk);
    chk("t3_nacks", LW'(acks.size()), 2);
    if (acks.size() >= 2) chk("t3_spacing", LW'(acks[1] - acks[0]), LW'(LAT0 + 1));

    // Input churn during WAIT.
    run_req(32'hE0, 1'b0, '0, 1);
    chk("t4_rd_churn", rd0, LW'(256'h1234));
    d5 = rnd256();
    run_req(32'hA0, 1'b1, d5, 1);
    run_req(32'hA0, 1'b0, '0, 0);
    chk("t4_wr_churn", rd0, d5);

    // Reset in the middle of a write to line 2.
    d_old = rnd256(); d_new = rnd256();
    run_req(32'h40, 1'b1, d_old, 0);
    @(negedge clk);
    addr = 32'h40; wr = 1'b1; din = d_new; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy_pre", LW'(busy0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ack_rst", LW'(ack0), '0);
    chk("t5_busy_rst", LW'(busy0), '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(32'h40, 1'b0, '0, 0);
    chk("t5_keep_old", rd0, d_old);
    chk("t5_fast_new", rd1, d_new);

    // Address aliasing and the LATENCY=1 instance.
    dz = rnd256();
    run_req(32'h4000, 1'b1, dz, 0);
    run_req(32'h0, 1'b0, '0, 0);
    chk("t6_alias0", rd0, dz);
    chk("t6_alias1", rd1, dz);
    chk("t6_lat1", LW'(lat1), 1);

    // Randomized traffic over lines 0..15 with aliased upper address bits.
    for (int t = 0; t < 40; t++) begin
      run_req(line_addr($urandom_range(15)), 1'($urandom()), rnd256(), 1'($urandom()));
      chk("rnd_lat", LW'(lat0), LW'(LAT0));
    end

    mon_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
